// File: rtl/hs_fifo_pkt_wr_guard.sv
// Packet write guard in front of a packet-mode FIFO: length limit, error drop, drop request, stats.
// Latency: wr_en/wr_last/wr_data combinational with the accepted beat; wr_drop, busy, counters one cycle later.
// Backpressure: s_ready follows ~fifo_full while passing, forced high while discarding, low during wr_drop and reset.

package hs_fifo_pkt_wr_guard_pkg;
    typedef enum logic {FALSE = 1'b0, TRUE = 1'b1} bool_e;
endpackage

module hs_fifo_pkt_wr_guard
    import hs_fifo_pkt_wr_guard_pkg::*;
#(
    parameter type   DATA_TYPE   = logic [15:0],
    parameter int    FIFO_DEPTH  = 32,
    parameter int    MAX_PKT_LEN = 32,
    parameter bool_e EN_STATS    = FALSE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  DATA_TYPE    s_data,
    input  logic        s_last,
    input  logic        s_err,
    input  logic        fifo_full,
    output logic        wr_en,
    output DATA_TYPE    wr_data,
    output logic        wr_last,
    output logic        wr_drop,
    output logic        busy,
    output logic [31:0] pkt_ok_cnt,
    output logic [31:0] pkt_drop_cnt
);

    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

    // A packet longer than the FIFO could never be committed, so reject such configurations.
    generate
        if (MAX_PKT_LEN < 1) begin : g_bad_len
            $error("hs_fifo_pkt_wr_guard: MAX_PKT_LEN must be >= 1");
        end
        if (MAX_PKT_LEN > FIFO_DEPTH) begin : g_bad_depth
            $error("hs_fifo_pkt_wr_guard: MAX_PKT_LEN must not exceed FIFO_DEPTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PASS, DISCARD} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [31:0]        ok_cnt_q;
    logic [31:0]        drop_cnt_q;

    logic acc;
    logic in_pkt;
    logic oversize;
    logic bad_end;
    logic drop_hit;

    // Ready: closed in reset and in the rollback cycle; discarding ignores the FIFO since nothing is written.
    always_comb begin
        s_ready = 1'b0;
        if (!rst && !wr_drop) begin
            s_ready = (state_q == DISCARD) ? 1'b1 : ~fifo_full;
        end
    end

    assign acc      = s_valid & s_ready;
    assign in_pkt   = (state_q != DISCARD);
    assign oversize = (beat_cnt_q == CNT_W'(MAX_PKT_LEN));
    assign bad_end  = s_last & s_err;
    // Oversize takes priority over the error flag; either way the packet is rolled back once.
    assign drop_hit = acc & in_pkt & (oversize | bad_end);

    assign wr_en    = acc & in_pkt & ~oversize & ~bad_end;
    assign wr_last  = wr_en & s_last;
    assign wr_data  = s_data;
    assign busy     = (state_q != IDLE);

    // Packet FSM, beat counter and the registered one-cycle rollback request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            wr_drop    <= 1'b0;
        end else begin
            wr_drop <= drop_hit;
            if (acc) begin
                case (state_q)
                    DISCARD: begin
                        if (s_last) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        if (oversize) begin
                            beat_cnt_q <= '0;
                            state_q    <= s_last ? IDLE : DISCARD;
                        end else if (s_last) begin
                            // Covers both a good commit and an errored last beat.
                            beat_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                            state_q    <= PASS;
                        end
                    end
                endcase
            end
        end
    end

    // Saturating packet statistics; held at zero when stats are disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else if (EN_STATS == TRUE) begin
            if (wr_last && (ok_cnt_q != 32'hFFFF_FFFF)) begin
                ok_cnt_q <= ok_cnt_q + 32'd1;
            end
            if (drop_hit && (drop_cnt_q != 32'hFFFF_FFFF)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_ok_cnt   = (EN_STATS == TRUE) ? ok_cnt_q   : 32'd0;
    assign pkt_drop_cnt = (EN_STATS == TRUE) ? drop_cnt_q : 32'd0;

endmodule

// File: tb/tb_hs_fifo_pkt_wr_guard.sv
// Directed bench for hs_fifo_pkt_wr_guard: two instances (MAX_PKT_LEN 32 and 4) with separate valids.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Expected values are hand-derived per step.

module tb_hs_fifo_pkt_wr_guard;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid_a, s_valid_b;
    logic [15:0] s_data;
    logic        s_last, s_err, fifo_full;

    logic        s_ready_a, wr_en_a, wr_last_a, wr_drop_a, busy_a;
    logic [15:0] wr_data_a;
    logic [31:0] ok_a, drop_a;
    logic        s_ready_b, wr_en_b, wr_last_b, wr_drop_b, busy_b;
    logic [15:0] wr_data_b;
    logic [31:0] ok_b, drop_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hs_fifo_pkt_wr_guard #(
        .DATA_TYPE   (logic [15:0]),
        .FIFO_DEPTH  (32),
        .MAX_PKT_LEN (32),
        .EN_STATS    (hs_fifo_pkt_wr_guard_pkg::TRUE)
    ) u_a (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid_a),
        .s_ready      (s_ready_a),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_err        (s_err),
        .fifo_full    (fifo_full),
        .wr_en        (wr_en_a),
        .wr_data      (wr_data_a),
        .wr_last      (wr_last_a),
        .wr_drop      (wr_drop_a),
        .busy         (busy_a),
        .pkt_ok_cnt   (ok_a),
        .pkt_drop_cnt (drop_a)
    );

    hs_fifo_pkt_wr_guard #(
        .DATA_TYPE   (logic [15:0]),
        .FIFO_DEPTH  (8),
        .MAX_PKT_LEN (4),
        .EN_STATS    (hs_fifo_pkt_wr_guard_pkg::TRUE)
    ) u_b (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid_b),
        .s_ready      (s_ready_b),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_err        (s_err),
        .fifo_full    (fifo_full),
        .wr_en        (wr_en_b),
        .wr_data      (wr_data_b),
        .wr_last      (wr_last_b),
        .wr_drop      (wr_drop_b),
        .busy         (busy_b),
        .pkt_ok_cnt   (ok_b),
        .pkt_drop_cnt (drop_b)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus on the falling edge, then settle before sampling.
    task automatic drv(input logic va, input logic vb, input logic [15:0] d,
                       input logic l, input logic e, input logic f);
        @(negedge clk);
        s_valid_a = va;
        s_valid_b = vb;
        s_data    = d;
        s_last    = l;
        s_err     = e;
        fifo_full = f;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        s_valid_a = 1'b1;
        s_valid_b = 1'b1;
        s_data    = 16'h0;
        s_last    = 1'b0;
        s_err     = 1'b0;
        fifo_full = 1'b0;
        #2;
        // Reset state, with valid asserted to show nothing is accepted.
        chk1 ("rst_s_ready_a", s_ready_a, 1'b0);
        chk1 ("rst_wr_en_a",   wr_en_a,   1'b0);
        chk1 ("rst_wr_drop_a", wr_drop_a, 1'b0);
        chk1 ("rst_busy_a",    busy_a,    1'b0);
        chk32("rst_ok_a",      ok_a,      32'd0);
        chk32("rst_drop_a",    drop_a,    32'd0);
        chk1 ("rst_s_ready_b", s_ready_b, 1'b0);
        drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Good 4-beat packet.
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 1'b0, 16'(i), (i == 4), 1'b0, 1'b0);
            chk1 ("t1_wr_en",   wr_en_a,   1'b1);
            chk1 ("t1_wr_last", wr_last_a, (i == 4));
            chk16("t1_wr_data", wr_data_a, 16'(i));
            chk1 ("t1_wr_drop", wr_drop_a, 1'b0);
            if (i > 1) chk1("t1_busy", busy_a, 1'b1);
        end
        drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk32("t1_ok",      ok_a,      32'd1);
        chk32("t1_drop",    drop_a,    32'd0);
        chk1 ("t1_busy_end", busy_a,   1'b0);
        chk1 ("t1_wr_drop_end", wr_drop_a, 1'b0);

        // 5-beat packet ending with error, then a 1-beat good packet waiting behind it.
        for (int i = 1; i <= 5; i++) begin
            drv(1'b1, 1'b0, 16'h0010 + 16'(i), (i == 5), (i == 5), 1'b0);
            chk1("t2_wr_en",   wr_en_a,   (i != 5));
            chk1("t2_wr_last", wr_last_a, 1'b0);
        end
        drv(1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0);
        chk1 ("t2_wr_drop",      wr_drop_a, 1'b1);
        chk1 ("t2_ready_in_drop", s_ready_a, 1'b0);
        chk1 ("t2_wr_en_in_drop", wr_en_a,  1'b0);
        chk32("t2_drop_cnt",     drop_a,    32'd1);
        drv(1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0);
        chk1 ("t2_wr_drop_once", wr_drop_a, 1'b0);
        chk1 ("t2_next_wr_en",   wr_en_a,   1'b1);
        chk1 ("t2_next_wr_last", wr_last_a, 1'b1);
        drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk32("t2_ok",   ok_a,   32'd2);
        chk32("t2_drop", drop_a, 32'd1);

        // MAX_PKT_LEN=4: 7-beat packet, tail discarded while FIFO reports full.
        for (int i = 1; i <= 5; i++) begin
            drv(1'b0, 1'b1, 16'h0020 + 16'(i), 1'b0, 1'b0, 1'b0);
            chk1("t3_wr_en",  wr_en_b,   (i <= 4));
            chk1("t3_s_ready", s_ready_b, 1'b1);
        end
        drv(1'b0, 1'b1, 16'h0026, 1'b0, 1'b0, 1'b1);
        chk1 ("t3_wr_drop",      wr_drop_b, 1'b1);
        chk1 ("t3_ready_in_drop", s_ready_b, 1'b0);
        chk1 ("t3_wr_en_in_drop", wr_en_b,  1'b0);
        chk32("t3_drop_cnt",     drop_b,    32'd1);
        drv(1'b0, 1'b1, 16'h0026, 1'b0, 1'b0, 1'b1);
        chk1 ("t3_disc_ready",   s_ready_b, 1'b1);
        chk1 ("t3_disc_wr_en",   wr_en_b,   1'b0);
        chk1 ("t3_disc_drop",    wr_drop_b, 1'b0);
        chk1 ("t3_disc_busy",    busy_b,    1'b1);
        drv(1'b0, 1'b1, 16'h0027, 1'b1, 1'b0, 1'b1);
        chk1 ("t3_disc_last_ready", s_ready_b, 1'b1);
        chk1 ("t3_disc_last_wr_en", wr_en_b,   1'b0);
        drv(1'b0, 1'b1, 16'h0031, 1'b0, 1'b0, 1'b0);
        chk1 ("t3_idle_busy",    busy_b,    1'b0);
        chk1 ("t3_good1_wr_en",  wr_en_b,   1'b1);
        chk1 ("t3_good1_wr_last", wr_last_b, 1'b0);
        chk16("t3_good1_data",   wr_data_b, 16'h0031);
        drv(1'b0, 1'b1, 16'h0032, 1'b1, 1'b0, 1'b0);
        chk1 ("t3_good2_wr_en",  wr_en_b,   1'b1);
        chk1 ("t3_good2_wr_last", wr_last_b, 1'b1);
        drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk32("t3_ok",   ok_b,   32'd1);
        chk32("t3_drop", drop_b, 32'd1);
        chk1 ("t3_busy_end", busy_b, 1'b0);

        // fifo_full for 3 cycles in the middle of a packet.
        drv(1'b1, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b0);
        chk1("t4_b0_wr_en", wr_en_a, 1'b1);
        drv(1'b1, 1'b0, 16'h0041, 1'b0, 1'b0, 1'b0);
        chk1("t4_b1_wr_en", wr_en_a, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b1);
            chk1("t4_full_ready", s_ready_a, 1'b0);
            chk1("t4_full_wr_en", wr_en_a,   1'b0);
            chk1("t4_full_busy",  busy_a,    1'b1);
        end
        drv(1'b1, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0);
        chk1 ("t4_b2_wr_en", wr_en_a,   1'b1);
        chk16("t4_b2_data",  wr_data_a, 16'h0042);
        drv(1'b1, 1'b0, 16'h0043, 1'b1, 1'b0, 1'b0);
        chk1 ("t4_b3_wr_en",   wr_en_a,   1'b1);
        chk1 ("t4_b3_wr_last", wr_last_a, 1'b1);
        drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk32("t4_ok", ok_a, 32'd3);

        // Asynchronous reset in the middle of a packet.
        drv(1'b1, 1'b0, 16'h0050, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 16'h0051, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 16'h0052, 1'b0, 1'b0, 1'b0);
        chk1("t5_pre_wr_en", wr_en_a, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1 ("t5_rst_ready",   s_ready_a, 1'b0);
        chk1 ("t5_rst_wr_en",   wr_en_a,   1'b0);
        chk1 ("t5_rst_busy",    busy_a,    1'b0);
        chk1 ("t5_rst_wr_drop", wr_drop_a, 1'b0);
        chk32("t5_rst_ok",      ok_a,      32'd0);
        chk32("t5_rst_drop",    drop_a,    32'd0);
        drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk1("t5_post_wr_drop", wr_drop_a, 1'b0);
        chk1("t5_post_busy",    busy_a,    1'b0);
        drv(1'b1, 1'b0, 16'h0060, 1'b1, 1'b0, 1'b0);
        chk1("t5_new_wr_en",   wr_en_a,   1'b1);
        chk1("t5_new_wr_last", wr_last_a, 1'b1);
        drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk32("t5_new_ok", ok_a, 32'd1);

        // Drop counter saturation.
        @(negedge clk);
        force u_a.drop_cnt_q = 32'hFFFF_FFFE;
        #1;
        release u_a.drop_cnt_q;
        #1;
        chk32("t6_preset", drop_a, 32'hFFFF_FFFE);
        for (int k = 0; k < 2; k++) begin
            drv(1'b1, 1'b0, 16'h0070, 1'b1, 1'b1, 1'b0);
            chk1 ("t6_err_wr_en", wr_en_a, 1'b0);
            drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
            chk1 ("t6_wr_drop", wr_drop_a, 1'b1);
            chk32("t6_drop_sat", drop_a, 32'hFFFF_FFFF);
        end
        drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk32("t6_drop_hold", drop_a, 32'hFFFF_FFFF);
        chk32("t6_ok_hold",   ok_a,   32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs_fifo_pkt_wr_guard.md
# hs_fifo_pkt_wr_guard

Packet write guard placed directly upstream of the `hs_fifo_sfifo` write port when that FIFO runs with packet mode and packet drop enabled. Accepts a valid/ready packet stream with `last` and `err` flags, enforces a maximum packet length, and forwards beats as FIFO write strobes. It issues a drop request so the FIFO discards the uncommitted part of any oversize or errored packet, and it keeps saturating good/dropped packet counters.

## Interface
Parameters:
- `DATA_TYPE`, `logic[15:0]`: beat payload type.
- `FIFO_DEPTH`, 32: depth of the downstream FIFO; elaboration check `MAX_PKT_LEN <= FIFO_DEPTH`.
- `MAX_PKT_LEN`, 32: maximum accepted beats per packet; elaboration check `>= 1`.
- `EN_STATS`, `bool_e` FALSE: when FALSE, both counters are tied to 0.

Ports:
- `clk` in 1: the only clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_valid` in 1: upstream beat valid.
- `s_ready` out 1: upstream beat ready.
- `s_data` in DATA_TYPE: beat payload.
- `s_last` in 1: final beat of the packet.
- `s_err` in 1: packet error flag, sampled only on the `s_last` beat.
- `fifo_full` in 1: full flag from the FIFO.
- `wr_en` out 1: FIFO write strobe.
- `wr_data` out DATA_TYPE: equals `s_data`.
- `wr_last` out 1: commit-packet flag, valid with `wr_en`.
- `wr_drop` out 1: one-cycle request that rolls back the FIFO's uncommitted beats.
- `busy` out 1: a packet is in progress (state ≠ IDLE).
- `pkt_ok_cnt` out 32: packets committed, saturating.
- `pkt_drop_cnt` out 32: packets dropped, saturating.

## Operation
- Accept condition: `acc = s_valid & s_ready`.
- State machine: IDLE, PASS, DISCARD.
- `beat_cnt` is $clog2(MAX_PKT_LEN+1) bits wide and counts beats written for the current packet.
- `s_ready`:
  - 0 while `rst` is high.
  - 0 in any cycle where `wr_drop` is high.
  - Otherwise 1 in DISCARD, and `~fifo_full` in IDLE/PASS.
- Accepted beat in IDLE/PASS, first matching rule wins:
  - Oversize (`beat_cnt == MAX_PKT_LEN`):
    - No write; `wr_drop` goes high next cycle; `pkt_drop_cnt` +1.
    - If `s_last`: go to IDLE. Else: go to DISCARD.
    - `beat_cnt` → 0.
  - `s_last & s_err`:
    - No write; `wr_drop` goes high next cycle; `pkt_drop_cnt` +1.
    - Go to IDLE; `beat_cnt` → 0.
  - `s_last`:
    - `wr_en=1`, `wr_last=1`; `pkt_ok_cnt` +1.
    - Go to IDLE; `beat_cnt` → 0.
  - Otherwise:
    - `wr_en=1`, `wr_last=0`; `beat_cnt` +1.
    - Go to / stay in PASS.
- DISCARD: accepted beats are swallowed with no write. On the accepted `s_last` beat, go to IDLE. Counters do not change (the drop was already counted).
- `s_err` on a beat without `s_last` is ignored.
- A single-beat errored packet still pulses `wr_drop`; the FIFO treats this as a no-op.
- Counters stick at 0xFFFF_FFFF.
- Reset values: state IDLE, `beat_cnt` 0, `wr_drop` 0, both counters 0, `busy` 0, `wr_en` 0, `s_ready` 0.
- Reset asserted mid-packet abandons the packet; no `wr_drop` is issued. The FIFO is reset on the same `rst`.

## Timing
- `wr_en`, `wr_last`, `wr_data` are combinational from the accepted beat: zero latency, same cycle as `acc`.
- `wr_drop` is registered: high exactly one cycle, the cycle after the offending beat is accepted.
- The next packet's first beat can be accepted no earlier than the cycle after the `wr_drop` cycle.
- After a good `s_last`, the next packet's first beat can be accepted in the very next cycle.
- `wr_en` and `wr_drop` are never high in the same cycle.
- `fifo_full` rising in the middle of a packet stalls only `s_ready`; packet state is held.
- `busy` and the counters are registered and update on the cycle after the triggering acceptance.
- Throughput: one beat per cycle when not full and not dropping.

## Test plan
- Good 4-beat packet (0x0001..0x0004), `MAX_PKT_LEN=32` → four `wr_en` in consecutive cycles, `wr_last` only on 0x0004, `pkt_ok_cnt=1`, no `wr_drop`.
- 5-beat packet ending with `s_err=1` → 4 writes, none with `wr_last`; 5th beat not written; `wr_drop` high one cycle after it; `s_ready=0` in that cycle; `pkt_drop_cnt=1`.
- `MAX_PKT_LEN=4`, 7-beat packet → beats 1–4 written; beat 5 not written and triggers `wr_drop`; beats 6–7 swallowed in DISCARD with `s_ready=1` even while `fifo_full=1`; then a good 2-beat packet commits and `pkt_ok_cnt=1`.
- `fifo_full` held high for 3 cycles mid-packet → `s_ready=0` and no `wr_en` for those 3 cycles; stream resumes with `beat_cnt` intact and the packet commits correctly.
- `rst` pulsed asynchronously mid-packet (between clock edges) → outputs reach reset values immediately; `busy=0`; no `wr_drop`; the next packet is handled normally.
- Force `pkt_drop_cnt` to 0xFFFF_FFFE, then send two errored packets → counter reads 0xFFFF_FFFF and stays there.
